// File: rtl/vga_pixel_clk_gen.sv
// ---------------------------------------------------------------------------
// vga_pixel_clk_gen
//   Synthesizable replacement for the vendor VGA PLL. Divides the fast board
//   clock by an integer ratio into a 50 % duty pixel clock. It also provides a
//   clock-enable pulse for logic that stays in the VGA_Clk domain, and a lock
//   flag that rises once the divider has run a fixed number of full periods.
//
// Parameters
//   DIV_RATIO  : c0 = VGA_Clk / DIV_RATIO, 2..1024
//   LOCK_DELAY : full c0 periods after reset before locked rises, 1..65535
//
// Ports
//   VGA_Clk : input  - fast reference clock; every register runs on it
//   Reset   : input  - asynchronous, active-high reset
//   c0      : output - divided pixel clock, 50 % duty
//   c0_en   : output - one VGA_Clk-cycle pulse, high in the cycle before
//                      each c0 rising edge
//   locked  : output - high once LOCK_DELAY full c0 periods have elapsed
// ---------------------------------------------------------------------------
module vga_pixel_clk_gen #(
    parameter int DIV_RATIO  = 2,
    parameter int LOCK_DELAY = 16
) (
    input  logic VGA_Clk,
    input  logic Reset,
    output logic c0,
    output logic c0_en,
    output logic locked
);

    if (DIV_RATIO < 2 || DIV_RATIO > 1024) begin : g_bad_div_ratio
        $error("vga_pixel_clk_gen: DIV_RATIO must be in 2..1024");
    end
    if (LOCK_DELAY < 1 || LOCK_DELAY > 65535) begin : g_bad_lock_delay
        $error("vga_pixel_clk_gen: LOCK_DELAY must be in 1..65535");
    end

    localparam int CW = $clog2(DIV_RATIO);
    localparam int LW = $clog2(LOCK_DELAY + 1);

    localparam logic [CW-1:0] CNT_LAST = CW'(DIV_RATIO - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(DIV_RATIO / 2);
    localparam logic [LW-1:0] LOCK_MAX = LW'(LOCK_DELAY);

    logic [CW-1:0] cnt_q;
    logic          pos_q;
    logic          neg_q;
    logic [LW-1:0] lock_cnt_q;
    logic [LW-1:0] lock_cnt_nxt;
    logic          locked_q;
    logic          wrap;

    assign wrap = (cnt_q == CNT_LAST);

    // The lock counter advances once per completed c0 period and then holds.
    always_comb begin
        lock_cnt_nxt = lock_cnt_q;
        if (wrap && (lock_cnt_q != LOCK_MAX)) begin
            lock_cnt_nxt = lock_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge VGA_Clk or posedge Reset) begin
        if (Reset) begin
            cnt_q      <= '0;
            pos_q      <= 1'b0;
            lock_cnt_q <= '0;
            locked_q   <= 1'b0;
        end else begin
            cnt_q      <= wrap ? '0 : cnt_q + 1'b1;
            // Phase 0 is counted as high, so the first edge after reset
            // starts a full-width high phase.
            pos_q      <= (cnt_q < CNT_HALF);
            lock_cnt_q <= lock_cnt_nxt;
            // Registered and sticky: rises on the same edge as the final
            // wrap and only clears on Reset.
            locked_q   <= locked_q | (lock_cnt_nxt == LOCK_MAX);
        end
    end

    // Odd ratios need an extra half cycle of high time. A falling-edge copy
    // of pos_q stretches the high phase. pos_q and neg_q overlap by half a
    // cycle at the falling transition, so their OR cannot glitch.
    if ((DIV_RATIO % 2) != 0) begin : g_odd
        always_ff @(negedge VGA_Clk or posedge Reset) begin
            if (Reset) begin
                neg_q <= 1'b0;
            end else begin
                neg_q <= pos_q;
            end
        end
    end else begin : g_even
        assign neg_q = 1'b0;
    end

    assign c0     = pos_q | neg_q;
    assign c0_en  = (cnt_q == '0) & ~Reset;
    assign locked = locked_q;

endmodule

// File: tb/tb_vga_pixel_clk_gen.sv
module tb_vga_pixel_clk_gen;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;
    logic c0_a, en_a, lk_a;
    logic c0_b, en_b, lk_b;
    logic c0_c, en_c, lk_c;

    // A: defaults (div 2, lock 16); B: div 3; C: div 4, lock 2
    vga_pixel_clk_gen #(.DIV_RATIO(2), .LOCK_DELAY(16)) dut_a (
        .VGA_Clk(clk), .Reset(rst_a), .c0(c0_a), .c0_en(en_a), .locked(lk_a));
    vga_pixel_clk_gen #(.DIV_RATIO(3), .LOCK_DELAY(16)) dut_b (
        .VGA_Clk(clk), .Reset(rst_b), .c0(c0_b), .c0_en(en_b), .locked(lk_b));
    vga_pixel_clk_gen #(.DIV_RATIO(4), .LOCK_DELAY(2)) dut_c (
        .VGA_Clk(clk), .Reset(rst_c), .c0(c0_c), .c0_en(en_c), .locked(lk_c));

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Posedges seen since each instance's reset release
    int ka = 0, kb = 0, kc = 0;
    logic [8:0] sb[$];

    // Half-cycle h after release: c0 is high when (h mod 2D) < D
    function automatic logic exp_c0(int k, int h, int d);
        int hh;
        if (k == 0) return 1'b0;
        hh = 2 * (k - 1) + h;
        return ((hh % (2 * d)) < d);
    endfunction

    function automatic logic exp_en(int k, int d, logic r);
        return !r && ((k % d) == 0);
    endfunction

    function automatic logic exp_lk(int k, int d, int l);
        return (k >= l * d);
    endfunction

    function automatic logic [2:0] exp3(int k, int h, int d, int l, logic r);
        return {exp_c0(k, h, d), exp_en(k, d, r), exp_lk(k, d, l)};
    endfunction

    task automatic push_exp(input int h);
        sb.push_back({exp3(ka, h, 2, 16, rst_a), exp3(kb, h, 3, 16, rst_b), exp3(kc, h, 4, 2, rst_c)});
    endtask

    task automatic pop_cmp();
        logic [8:0] e;
        if (sb.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        check("A.c0", c0_a, e[8]); check("A.en", en_a, e[7]); check("A.lk", lk_a, e[6]);
        check("B.c0", c0_b, e[5]); check("B.en", en_b, e[4]); check("B.lk", lk_b, e[3]);
        check("C.c0", c0_c, e[2]); check("C.en", en_c, e[1]); check("C.lk", lk_c, e[0]);
    endtask

    logic win = 1'b0;
    int en_pulses = 0;
    int rises_all = 0;
    int rises_win = 0;
    int lk_drops = 0;

    task automatic half_pos();
        @(posedge clk);
        if (!rst_a) ka++;
        if (!rst_b) kb++;
        if (!rst_c) kc++;
        push_exp(0);
        #1;
        pop_cmp();
        if (win && en_a) en_pulses++;
    endtask

    task automatic half_neg();
        @(negedge clk);
        push_exp(1);
        #1;
        pop_cmp();
    endtask

    task automatic run_cycles(input int n);
        repeat (n) begin
            half_pos();
            half_neg();
        end
    endtask

    always @(posedge c0_a) begin
        rises_all++;
        if (win) rises_win++;
    end
    always @(posedge c0_b) rises_all++;
    always @(posedge c0_c) rises_all++;
    always @(negedge lk_a) if (win) lk_drops++;

    // Waveform measurements of high time and period
    longint t_rise_b = 0, per_b = 0, hi_b = 0;
    longint t_rise_c = 0, per_c = 0, hi_c = 0;
    always @(posedge c0_b) begin
        if (t_rise_b > 0) per_b = $time - t_rise_b;
        t_rise_b = $time;
    end
    always @(negedge c0_b) hi_b = $time - t_rise_b;
    always @(posedge c0_c) begin
        if (t_rise_c > 0) per_c = $time - t_rise_c;
        t_rise_c = $time;
    end
    always @(negedge c0_c) hi_c = $time - t_rise_c;

    initial begin
        // Held in reset: everything low, no c0 edges
        run_cycles(10);
        check("rst_no_edges", rises_all, 0);

        // Release; all three instances run from the same point
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        ka = 0; kb = 0; kc = 0;
        #1;
        check("A.en_at_release", en_a, 1);
        check("A.c0_at_release", c0_a, 0);
        run_cycles(60);

        check("B.period", 32'(per_b), 60);
        check("B.high",   32'(hi_b), 30);

        // Short reset pulse on C during a c0 high phase after lock
        half_pos();
        check("C.pre_rst_c0", c0_c, 1);
        check("C.pre_rst_lk", lk_c, 1);
        #1 rst_c = 1'b1;
        kc = 0;
        #1;
        check("C.rst_c0", c0_c, 0);
        check("C.rst_lk", lk_c, 0);
        check("C.rst_en", en_c, 0);
        #3 rst_c = 1'b0;
        half_neg();
        run_cycles(20);
        check("C.high_after_rst", 32'(hi_c), 40);
        check("C.period_after_rst", 32'(per_c), 80);

        // Long run on A
        win = 1'b1;
        run_cycles(10000);
        win = 1'b0;
        check("A.rises_10k", rises_win, 5000);
        check("A.en_pulses_10k", en_pulses, 5000);
        check("A.lk_drops", lk_drops, 0);
        check("sb_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
